// File: rtl/wb_arbiter.sv
// Writeback arbiter: three single-entry source buffers drained round-robin into a
// registered register-file write port, with combinational bypass from pending writes.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [5:0]  alu_addr,
  input  logic [63:0] alu_data,
  input  logic        fpu_valid,
  output logic        fpu_ready,
  input  logic [5:0]  fpu_addr,
  input  logic [63:0] fpu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [5:0]  mem_addr,
  input  logic [63:0] mem_data,
  output logic        rf_write_enable,
  output logic [5:0]  rf_write_addr,
  output logic [63:0] rf_write_data,
  input  logic [5:0]  read_addr1,
  input  logic [5:0]  read_addr2,
  output logic        bypass_hit1,
  output logic [63:0] bypass_data1,
  output logic        bypass_hit2,
  output logic [63:0] bypass_data2,
  output logic        wb_busy
);

  localparam int NSRC = 3;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_FPU = 2'd1,
    SRC_MEM = 2'd2
  } src_e;

  function automatic src_e rr_next(input src_e s);
    case (s)
      SRC_ALU: return SRC_FPU;
      SRC_FPU: return SRC_MEM;
      default: return SRC_ALU;
    endcase
  endfunction

  logic [NSRC-1:0] src_valid, src_ready, accept;
  logic [5:0]      src_addr [NSRC];
  logic [63:0]     src_data [NSRC];

  logic [NSRC-1:0] buf_valid_q, buf_valid_d;
  logic [5:0]      buf_addr_q [NSRC];
  logic [63:0]     buf_data_q [NSRC];
  src_e            rr_start_q, rr_start_d;

  logic            gnt_vld;
  src_e            gnt_src;
  logic [NSRC-1:0] gnt_onehot;

  logic            rf_we_q, rf_we_d;
  logic [5:0]      rf_addr_q, rf_addr_d;
  logic [63:0]     rf_data_q, rf_data_d;

  logic [5:0]      rd_addr [2];
  logic [1:0]      byp_hit;
  logic [63:0]     byp_data [2];

  assign src_valid   = {mem_valid, fpu_valid, alu_valid};
  assign src_addr[0] = alu_addr;
  assign src_addr[1] = fpu_addr;
  assign src_addr[2] = mem_addr;
  assign src_data[0] = alu_data;
  assign src_data[1] = fpu_data;
  assign src_data[2] = mem_data;

  // First full buffer found walking from the source after the last winner.
  always_comb begin
    src_e cand;
    gnt_vld = 1'b0;
    gnt_src = SRC_ALU;
    cand    = rr_start_q;
    for (int k = 0; k < NSRC; k++) begin
      if (!gnt_vld && buf_valid_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_src = cand;
      end
      cand = rr_next(cand);
    end
  end

  always_comb begin
    gnt_onehot = '0;
    if (gnt_vld) gnt_onehot[gnt_src] = 1'b1;
  end

  assign src_ready = ~buf_valid_q | gnt_onehot;
  assign accept    = src_valid & src_ready;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    buf_valid_d = (buf_valid_q & ~gnt_onehot) | accept;
    rr_start_d  = gnt_vld ? rr_next(gnt_src) : rr_start_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    if (gnt_vld) begin
      // Writes to x0 are consumed but never reach the register file.
      rf_we_d   = (buf_addr_q[gnt_src] != 6'd0);
      rf_addr_d = buf_addr_q[gnt_src];
      rf_data_d = buf_data_q[gnt_src];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= '0;
      rr_start_q  <= SRC_ALU;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      rr_start_q  <= rr_start_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
    end
  end

  // NOTE: buffer payloads are not reset; their valid bits alone decide whether they are used.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (accept[s]) begin
        buf_addr_q[s] <= src_addr[s];
        buf_data_q[s] <= src_data[s];
      end
    end
  end

  assign rd_addr[0] = read_addr1;
  assign rd_addr[1] = read_addr2;

  // Later matches override earlier ones: output stage < alu < fpu < mem.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      byp_hit[p]  = 1'b0;
      byp_data[p] = '0;
      if (rd_addr[p] != 6'd0) begin
        if (rf_we_q && rf_addr_q == rd_addr[p]) begin
          byp_hit[p]  = 1'b1;
          byp_data[p] = rf_data_q;
        end
        for (int s = 0; s < NSRC; s++) begin
          if (buf_valid_q[s] && buf_addr_q[s] == rd_addr[p]) begin
            byp_hit[p]  = 1'b1;
            byp_data[p] = buf_data_q[s];
          end
        end
      end
    end
  end

  assign alu_ready       = src_ready[0];
  assign fpu_ready       = src_ready[1];
  assign mem_ready       = src_ready[2];
  assign rf_write_enable = rf_we_q;
  assign rf_write_addr   = rf_addr_q;
  assign rf_write_data   = rf_data_q;
  assign bypass_hit1     = byp_hit[0];
  assign bypass_data1    = byp_data[0];
  assign bypass_hit2     = byp_hit[1];
  assign bypass_data2    = byp_data[1];
  assign wb_busy         = (|buf_valid_q) | rf_we_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus pushes expected register-file writes
// into a queue, and a negedge monitor pops and compares each write it observes.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, fpu_valid, mem_valid;
  logic        alu_ready, fpu_ready, mem_ready;
  logic [5:0]  alu_addr, fpu_addr, mem_addr;
  logic [63:0] alu_data, fpu_data, mem_data;
  logic        rf_write_enable;
  logic [5:0]  rf_write_addr;
  logic [63:0] rf_write_data;
  logic [5:0]  read_addr1, read_addr2;
  logic        bypass_hit1, bypass_hit2;
  logic [63:0] bypass_data1, bypass_data2;
  logic        wb_busy;

  typedef struct {
    logic [5:0]  addr;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   d;

  wb_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_addr        (alu_addr),
    .alu_data        (alu_data),
    .fpu_valid       (fpu_valid),
    .fpu_ready       (fpu_ready),
    .fpu_addr        (fpu_addr),
    .fpu_data        (fpu_data),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .read_addr1      (read_addr1),
    .read_addr2      (read_addr2),
    .bypass_hit1     (bypass_hit1),
    .bypass_data1    (bypass_data1),
    .bypass_hit2     (bypass_hit2),
    .bypass_data2    (bypass_data2),
    .wb_busy         (wb_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [5:0] a, input logic [63:0] dat, input int c);
    exp_t e;
    e.addr = a;
    e.data = dat;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic clear_valids();
    alu_valid = 1'b0;
    fpu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  // Every observed write must match the oldest expectation, in value and in cycle.
  always @(negedge clk) begin
    if (rf_write_enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(rf_write_enable), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(rf_write_addr), 64'(mon_e.addr));
        check("wr_data", rf_write_data, mon_e.data);
        check("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      check("missed_write", 64'(rf_write_enable), 64'd1);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    alu_addr = '0; fpu_addr = '0; mem_addr = '0;
    alu_data = '0; fpu_data = '0; mem_data = '0;
    fpu_valid = 1'b0; mem_valid = 1'b0;
    read_addr1 = '0; read_addr2 = '0;

    // Reset with a request held high: it must be ignored.
    rst = 1'b1;
    alu_valid = 1'b1; alu_addr = 6'd7; alu_data = 64'hdead;
    tick();
    tick();
    rst = 1'b0;
    clear_valids();
    @(negedge clk);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    check("rst_fpu_ready", 64'(fpu_ready), 64'd1);
    check("rst_mem_ready", 64'(mem_ready), 64'd1);
    check("rst_busy", 64'(wb_busy), 64'd0);
    check("rst_we", 64'(rf_write_enable), 64'd0);
    check("rst_waddr", 64'(rf_write_addr), 64'd0);
    check("rst_wdata", rf_write_data, 64'd0);
    repeat (3) tick();

    // Contention: alu, fpu, mem in one cycle drain in round-robin order.
    d = cyc;
    alu_valid = 1'b1; alu_addr = 6'd1;  alu_data = 64'h101;
    fpu_valid = 1'b1; fpu_addr = 6'd33; fpu_data = 64'h2033;
    mem_valid = 1'b1; mem_addr = 6'd2;  mem_data = 64'h302;
    push_exp(6'd1, 64'h101, d + 2);
    push_exp(6'd33, 64'h2033, d + 3);
    push_exp(6'd2, 64'h302, d + 4);
    tick();
    clear_valids();
    @(negedge clk);
    check("cont1_alu_ready", 64'(alu_ready), 64'd1);
    check("cont1_fpu_ready", 64'(fpu_ready), 64'd0);
    check("cont1_mem_ready", 64'(mem_ready), 64'd0);
    check("cont1_busy", 64'(wb_busy), 64'd1);
    tick();
    @(negedge clk);
    check("cont2_fpu_ready", 64'(fpu_ready), 64'd1);
    check("cont2_mem_ready", 64'(mem_ready), 64'd0);
    tick();
    @(negedge clk);
    check("cont3_mem_ready", 64'(mem_ready), 64'd1);
    repeat (2) tick();

    // Single uncontended write: enable for exactly one cycle.
    d = cyc;
    alu_valid = 1'b1; alu_addr = 6'd5; alu_data = 64'hAA;
    push_exp(6'd5, 64'hAA, d + 2);
    tick();
    clear_valids();
    repeat (2) tick();
    @(negedge clk);
    check("single_we_drop", 64'(rf_write_enable), 64'd0);
    check("single_busy_idle", 64'(wb_busy), 64'd0);

    // Write to x0 is consumed without a register-file write.
    mem_valid = 1'b1; mem_addr = 6'd0; mem_data = 64'hFF;
    read_addr1 = 6'd0;
    tick();
    clear_valids();
    @(negedge clk);
    check("x0_mem_ready_granted", 64'(mem_ready), 64'd1);
    check("x0_bypass_hit1", 64'(bypass_hit1), 64'd0);
    check("x0_busy_pending", 64'(wb_busy), 64'd1);
    tick();
    @(negedge clk);
    check("x0_we", 64'(rf_write_enable), 64'd0);
    check("x0_mem_ready", 64'(mem_ready), 64'd1);
    check("x0_busy_done", 64'(wb_busy), 64'd0);
    tick();

    // Bypass from the fpu buffer, then from the output stage, then gone.
    d = cyc;
    fpu_valid = 1'b1; fpu_addr = 6'd40; fpu_data = 64'h1234;
    read_addr2 = 6'd40;
    push_exp(6'd40, 64'h1234, d + 2);
    @(negedge clk);
    check("byp_before_hit2", 64'(bypass_hit2), 64'd0);
    tick();
    clear_valids();
    @(negedge clk);
    check("byp_buf_hit2", 64'(bypass_hit2), 64'd1);
    check("byp_buf_data2", bypass_data2, 64'h1234);
    tick();
    @(negedge clk);
    check("byp_out_hit2", 64'(bypass_hit2), 64'd1);
    check("byp_out_data2", bypass_data2, 64'h1234);
    tick();
    @(negedge clk);
    check("byp_after_hit2", 64'(bypass_hit2), 64'd0);
    check("byp_after_data2", bypass_data2, 64'd0);
    read_addr2 = 6'd0;

    // Same address in two buffers: mem > alu > output stage. Pointer now at mem.
    tick();
    d = cyc;
    alu_valid = 1'b1; alu_addr = 6'd9; alu_data = 64'h11;
    mem_valid = 1'b1; mem_addr = 6'd9; mem_data = 64'h22;
    read_addr1 = 6'd9;
    push_exp(6'd9, 64'h22, d + 2);
    push_exp(6'd9, 64'h11, d + 3);
    tick();
    clear_valids();
    @(negedge clk);
    check("prio_mem_hit1", 64'(bypass_hit1), 64'd1);
    check("prio_mem_data1", bypass_data1, 64'h22);
    tick();
    @(negedge clk);
    check("prio_alu_over_out", bypass_data1, 64'h11);
    tick();
    @(negedge clk);
    check("prio_out_data1", bypass_data1, 64'h11);
    tick();
    @(negedge clk);
    check("prio_after_hit1", 64'(bypass_hit1), 64'd0);
    read_addr1 = 6'd0;
    tick();

    // Streaming from alu: new request replaces the entry being granted.
    d = cyc;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1;
      alu_addr  = 6'(3 + i);
      alu_data  = 64'(32'h500 + i);
      push_exp(6'(3 + i), 64'(32'h500 + i), d + i + 2);
      @(negedge clk);
      check("stream_alu_ready", 64'(alu_ready), 64'd1);
      tick();
    end
    clear_valids();
    repeat (3) tick();

    // Reset while buffers are full: pending writes are dropped.
    alu_valid = 1'b1; alu_addr = 6'd10; alu_data = 64'h610;
    fpu_valid = 1'b1; fpu_addr = 6'd34; fpu_data = 64'h634;
    mem_valid = 1'b1; mem_addr = 6'd12; mem_data = 64'h612;
    tick();
    clear_valids();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy_before", 64'(wb_busy), 64'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(wb_busy), 64'd0);
    check("midrst_we", 64'(rf_write_enable), 64'd0);
    check("midrst_alu_ready", 64'(alu_ready), 64'd1);
    check("midrst_fpu_ready", 64'(fpu_ready), 64'd1);
    check("midrst_mem_ready", 64'(mem_ready), 64'd1);
    repeat (3) tick();

    // After reset the pointer is back at alu, so alu wins over mem.
    d = cyc;
    alu_valid = 1'b1; alu_addr = 6'd11; alu_data = 64'h711;
    mem_valid = 1'b1; mem_addr = 6'd13; mem_data = 64'h713;
    push_exp(6'd11, 64'h711, d + 2);
    push_exp(6'd13, 64'h713, d + 3);
    tick();
    clear_valids();
    repeat (4) tick();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
